// File: rtl/nco_hop_sequencer.sv
// nco_hop_sequencer: plays a small table of (wave select, tuning word, dwell)
// entries into the NCO, holding each for its dwell time, one-shot or looped.
// The first entry is applied one cycle after start (LOAD); later entries are
// applied on the very edge the previous dwell expires so holds are back-to-back.
module nco_hop_sequencer #(
    parameter int DEPTH   = 8,
    parameter int SEL_W   = 3,
    parameter int FTW_W   = 16,
    parameter int DWELL_W = 16,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic               clk_50MHz,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [SEL_W-1:0]   cfg_wave,
    input  logic [FTW_W-1:0]   cfg_ftw,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic               cfg_ready,
    input  logic [IDX_W:0]     num_entries,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
    output logic [SEL_W-1:0]   wave_sel,
    output logic [FTW_W-1:0]   ftw,
    output logic               update,
    output logic [IDX_W-1:0]   cur_idx,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    localparam logic [IDX_W:0]     DEPTH_N    = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0]   IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]   IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]   IDX_MAX    = {IDX_W{1'b1}};
    localparam logic [IDX_W:0]     NUM_ZERO   = {(IDX_W+1){1'b0}};
    localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [SEL_W-1:0]   tbl_wave_r  [DEPTH];
    logic [FTW_W-1:0]   tbl_ftw_r   [DEPTH];
    logic [DWELL_W-1:0] tbl_dwell_r [DEPTH];

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic [IDX_W-1:0]   last_idx_r, last_idx_s;
    logic               loop_r, loop_s;
    logic [DWELL_W-1:0] cnt_r, cnt_s;
    logic [SEL_W-1:0]   wave_sel_r, wave_s;
    logic [FTW_W-1:0]   ftw_r, ftw_s;
    logic [IDX_W-1:0]   cur_idx_r, cur_idx_s;
    logic               update_r, done_r, busy_r;
    logic               apply_s, done_s;
    logic [IDX_W-1:0]   apply_idx_s, req_last_s;
    logic [DWELL_W-1:0] apply_dwell_s;
    logic               start_ok_s, is_last_s, dwell_end_s;

    // Request decode: clamp the requested length and qualify start (stop wins).
    always_comb begin
        start_ok_s  = start && !stop && (num_entries != NUM_ZERO);
        is_last_s   = (idx_r == last_idx_r);
        dwell_end_s = (cnt_r == DWELL_ZERO);
        if (num_entries > DEPTH_N) begin
            req_last_s = IDX_MAX;
        end else begin
            req_last_s = num_entries[IDX_W-1:0] - IDX_ONE;
        end
    end

    // State register.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (stop) begin
                    state_s = ST_IDLE;
                end else if (dwell_end_s && is_last_s && !loop_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DWELL;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output/datapath next values: decide which entry (if any) is applied this edge.
    always_comb begin
        idx_s       = idx_r;
        last_idx_s  = last_idx_r;
        loop_s      = loop_r;
        cnt_s       = cnt_r;
        apply_s     = 1'b0;
        apply_idx_s = idx_r;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    idx_s      = IDX_ZERO;
                    last_idx_s = req_last_s;
                    loop_s     = loop_en;
                end else begin
                    idx_s      = idx_r;
                end
            end
            ST_LOAD: begin
                if (!stop) begin
                    apply_s     = 1'b1;
                    apply_idx_s = idx_r;
                end else begin
                    apply_s     = 1'b0;
                end
            end
            ST_DWELL: begin
                if (stop) begin
                    apply_s = 1'b0;
                end else if (!dwell_end_s) begin
                    cnt_s = cnt_r - DWELL_ONE;
                end else if (!is_last_s) begin
                    apply_s     = 1'b1;
                    apply_idx_s = idx_r + IDX_ONE;
                end else if (loop_r) begin
                    apply_s     = 1'b1;
                    apply_idx_s = IDX_ZERO;
                end else begin
                    done_s = 1'b1;
                end
            end
            default: apply_s = 1'b0;
        endcase

        apply_dwell_s = tbl_dwell_r[apply_idx_s];
        if (apply_s) begin
            idx_s     = apply_idx_s;
            cur_idx_s = apply_idx_s;
            wave_s    = tbl_wave_r[apply_idx_s];
            ftw_s     = tbl_ftw_r[apply_idx_s];
            // A zero dwell behaves as a one-cycle hold.
            if (apply_dwell_s == DWELL_ZERO) begin
                cnt_s = DWELL_ZERO;
            end else begin
                cnt_s = apply_dwell_s - DWELL_ONE;
            end
        end else begin
            cur_idx_s = cur_idx_r;
            wave_s    = wave_sel_r;
            ftw_s     = ftw_r;
        end
    end

    // Registered outputs and sequencing registers; a stop leaves the outputs holding.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            idx_r      <= IDX_ZERO;
            last_idx_r <= IDX_ZERO;
            loop_r     <= 1'b0;
            cnt_r      <= DWELL_ZERO;
            wave_sel_r <= {SEL_W{1'b0}};
            ftw_r      <= {FTW_W{1'b0}};
            cur_idx_r  <= IDX_ZERO;
            update_r   <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            idx_r      <= idx_s;
            last_idx_r <= last_idx_s;
            loop_r     <= loop_s;
            cnt_r      <= cnt_s;
            wave_sel_r <= wave_s;
            ftw_r      <= ftw_s;
            cur_idx_r  <= cur_idx_s;
            update_r   <= apply_s;
            done_r     <= done_s;
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    // Hop table: cleared on reset, writable only while the sequencer is idle.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_wave_r[i]  <= {SEL_W{1'b0}};
                tbl_ftw_r[i]   <= {FTW_W{1'b0}};
                tbl_dwell_r[i] <= DWELL_ZERO;
            end
        end else if (cfg_we && !busy_r) begin
            tbl_wave_r[cfg_addr]  <= cfg_wave;
            tbl_ftw_r[cfg_addr]   <= cfg_ftw;
            tbl_dwell_r[cfg_addr] <= cfg_dwell;
        end else begin
            tbl_wave_r[cfg_addr]  <= tbl_wave_r[cfg_addr];
        end
    end

    assign wave_sel  = wave_sel_r;
    assign ftw       = ftw_r;
    assign update    = update_r;
    assign cur_idx   = cur_idx_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cfg_ready = ~busy_r;

endmodule
